// File: rtl/calc_engine.sv
// calc_engine: operand latches, 8-op sequencer with shift-add multiply
// and restoring divide, display value and active-low status LEDs.
module calc_engine #(
  parameter int WIDTH  = 8,
  parameter bit INV_IN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_number,
  input  logic [1:0]           key,
  input  logic                 start,
  input  logic [3:0]           arif,
  output logic [2*WIDTH-1:0]   ind,
  output logic [2*WIDTH-1:0]   result,
  output logic [2:0]           led,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 ovf
);

  localparam int W  = WIDTH;
  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] LD_NONE = 2'd0;
  localparam logic [1:0] LD_A    = 2'd1;
  localparam logic [1:0] LD_B    = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [1:0]    key_q, key_d;
  logic          start_q, start_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [3:0]    op_q, op_d;
  logic [W-1:0]  wb_q, wb_d;
  logic [W2-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W2-1:0] res_q, res_d;
  logic [W2-1:0] ind_q, ind_d;
  logic          err_q, err_d;
  logic          ovf_q, ovf_d;
  logic [1:0]    last_q, last_d;

  logic [1:0]    key_rise;
  logic          start_rise;
  logic          accept;
  logic          do_start;
  logic          do_load;
  logic [W-1:0]  cap;

  assign key_rise   = key & ~key_q;
  assign start_rise = start & ~start_q;
  assign accept     = (state_q != S_EXEC);
  assign do_start   = accept & start_rise;
  assign do_load    = accept & ~start_rise & (|key_rise);
  assign cap        = INV_IN ? ~in_number : in_number;

  // acc holds {partial, multiplier} for mul and {remainder, quotient} for div
  logic [W-1:0]  opa;
  logic [W:0]    mul_sum;
  logic [W2-1:0] mul_nxt;
  logic [W:0]    div_r;
  logic          div_ge;
  logic [W-1:0]  div_sub;
  logic [W2-1:0] div_nxt;
  logic [W:0]    add_s;
  logic [W:0]    sub_s;
  logic          dz;
  logic          multi;
  logic          last_step;

  assign opa     = acc_q[W-1:0];
  assign mul_sum = {1'b0, acc_q[W2-1:W]}
                 + (acc_q[0] ? {1'b0, wb_q} : '0);
  assign mul_nxt = {mul_sum, acc_q[W-1:1]};
  assign div_r   = acc_q[W2-1:W-1];
  assign div_ge  = (div_r >= {1'b0, wb_q});
  assign div_sub = div_r[W-1:0] - wb_q;
  assign div_nxt = div_ge
                 ? {div_sub, acc_q[W-2:0], 1'b1}
                 : {div_r[W-1:0], acc_q[W-2:0], 1'b0};
  assign add_s   = {1'b0, opa} + {1'b0, wb_q};
  assign sub_s   = {1'b0, opa} - {1'b0, wb_q};

  assign dz        = ((op_q == 4'd3) || (op_q == 4'd4)) && (wb_q == '0);
  assign multi     = (op_q == 4'd2)
                   || (((op_q == 4'd3) || (op_q == 4'd4)) && !dz);
  assign last_step = !multi || (cnt_q == CW'(W - 1));

  logic [W2-1:0] fin_res;
  logic          fin_err;
  logic          fin_ovf;

  always_comb begin
    fin_res = '0;
    fin_err = 1'b0;
    fin_ovf = 1'b0;
    case (op_q)
      4'd0: begin
        fin_res = {{(W-1){1'b0}}, add_s};
        fin_ovf = add_s[W];
      end
      4'd1: begin
        fin_res = {{W{1'b0}}, sub_s[W-1:0]};
        fin_ovf = sub_s[W];
      end
      4'd2: fin_res = mul_nxt;
      4'd3: begin
        fin_res = dz ? {{W{1'b0}}, {W{1'b1}}}
                     : {{W{1'b0}}, div_nxt[W-1:0]};
        fin_err = dz;
      end
      4'd4: begin
        fin_res = dz ? {{W{1'b0}}, opa}
                     : {{W{1'b0}}, div_nxt[W2-1:W]};
        fin_err = dz;
      end
      4'd5: fin_res = {{W{1'b0}}, opa & wb_q};
      4'd6: fin_res = {{W{1'b0}}, opa | wb_q};
      4'd7: fin_res = {{W{1'b0}}, opa ^ wb_q};
      default: fin_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    key_d   = key;
    start_d = start;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    wb_d    = wb_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    ind_d   = ind_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    last_d  = last_q;
    if (do_start) begin
      state_d = S_EXEC;
      op_d    = arif;
      wb_d    = b_q;
      acc_d   = {{W{1'b0}}, a_q};
      cnt_d   = '0;
      err_d   = 1'b0;
      ovf_d   = 1'b0;
    end else if (do_load) begin
      state_d = S_IDLE;
      if (key_rise[1]) a_d = cap;
      if (key_rise[0]) b_d = cap;
      ind_d  = {{W{1'b0}}, cap};
      last_d = key_rise[0] ? LD_B : LD_A;
    end
    if (state_q == S_EXEC) begin
      if (last_step) begin
        state_d = S_DONE;
        res_d   = fin_res;
        ind_d   = fin_res;
        err_d   = fin_err;
        ovf_d   = fin_ovf;
      end else begin
        acc_d = (op_q == 4'd2) ? mul_nxt : div_nxt;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      key_q   <= '1;
      start_q <= 1'b1;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      wb_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      ind_q   <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      last_q  <= LD_NONE;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      start_q <= start_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      wb_q    <= wb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      ind_q   <= ind_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    led = 3'b110;
    case (state_q)
      S_EXEC: led = 3'b111;
      S_DONE: led = err_q ? 3'b000 : 3'b010;
      default: begin
        case (last_q)
          LD_A:    led = 3'b101;
          LD_B:    led = 3'b011;
          default: led = 3'b110;
        endcase
      end
    endcase
  end

  assign ind    = ind_q;
  assign result = res_q;
  assign busy   = (state_q == S_EXEC);
  assign done   = (state_q == S_DONE);
  assign err    = err_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_calc_engine.sv
// Directed bench for calc_engine at WIDTH=8, INV_IN=1.
module tb_calc_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_number;
  logic [1:0]  key;
  logic        start;
  logic [3:0]  arif;
  logic [15:0] ind;
  logic [15:0] result;
  logic [2:0]  led;
  logic        busy;
  logic        done;
  logic        err;
  logic        ovf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  calc_engine #(.WIDTH(8), .INV_IN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_number(in_number), .key(key),
    .start(start), .arif(arif), .ind(ind), .result(result),
    .led(led), .busy(busy), .done(done), .err(err), .ovf(ovf)
  );

  task automatic load(input logic [1:0] k, input logic [7:0] v);
    @(negedge clk);
    in_number = ~v;
    key = k;
    @(negedge clk);
    key = 2'b00;
  endtask

  task automatic run_op(input logic [3:0] op, output int cyc,
                        output logic b0);
    @(negedge clk);
    arif = op;
    start = 1'b1;
    @(posedge clk);
    #1;
    b0 = busy;
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; key = 2'b00; start = 1'b0; arif = 4'd0;
    in_number = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ind !== 16'h0) begin
      errors++; $display("FAIL reset_ind got=%h exp=0000", ind);
    end
    checks++;
    if (result !== 16'h0) begin
      errors++; $display("FAIL reset_result got=%h exp=0000", result);
    end
    checks++;
    if (led !== 3'b110) begin
      errors++; $display("FAIL reset_led got=%b exp=110", led);
    end
    checks++;
    if ({busy, done, err, ovf} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=0000", {busy, done, err, ovf});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add;
    int c; logic b;
    load(2'b10, 8'd200);
    checks++;
    if (ind !== 16'd200 || led !== 3'b101) begin
      errors++;
      $display("FAIL load_a ind=%0d led=%b exp 200/101", ind, led);
    end
    load(2'b01, 8'd100);
    checks++;
    if (ind !== 16'd100 || led !== 3'b011) begin
      errors++;
      $display("FAIL load_b ind=%0d led=%b exp 100/011", ind, led);
    end
    run_op(4'd0, c, b);
    checks++;
    if (b !== 1'b1 || c !== 1) begin
      errors++; $display("FAIL add_timing busy=%b cyc=%0d exp 1/1", b, c);
    end
    checks++;
    if (result !== 16'h012C || ovf !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL add_res got=%h ovf=%b exp 012C/1", result, ovf);
    end
    checks++;
    if (done !== 1'b1 || led !== 3'b010 || ind !== 16'h012C) begin
      errors++;
      $display("FAIL add_done done=%b led=%b ind=%h exp 1/010/012C",
               done, led, ind);
    end
  endtask

  task automatic test_sub_logic;
    int c; logic b;
    load(2'b10, 8'd5);
    load(2'b01, 8'd7);
    run_op(4'd1, c, b);
    checks++;
    if (result !== 16'h00FE || ovf !== 1'b1 || c !== 1) begin
      errors++;
      $display("FAIL sub got=%h ovf=%b cyc=%0d exp 00FE/1/1",
               result, ovf, c);
    end
    load(2'b11, 8'd0);
    checks++;
    if (led !== 3'b011 || done !== 1'b0) begin
      errors++;
      $display("FAIL dual_load led=%b done=%b exp 011/0", led, done);
    end
    run_op(4'd5, c, b);
    checks++;
    if (result !== 16'h0 || ovf !== 1'b0) begin
      errors++; $display("FAIL and0 got=%h ovf=%b exp 0000/0", result, ovf);
    end
    load(2'b10, 8'hAA);
    load(2'b01, 8'h0F);
    run_op(4'd7, c, b);
    checks++;
    if (result !== 16'h00A5) begin
      errors++; $display("FAIL xor got=%h exp 00A5", result);
    end
    run_op(4'd6, c, b);
    checks++;
    if (result !== 16'h00AF) begin
      errors++; $display("FAIL or got=%h exp 00AF", result);
    end
  endtask

  task automatic test_mul_busy;
    int c; logic b;
    load(2'b11, 8'd255);
    @(negedge clk);
    arif = 4'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    b = busy;
    start = 1'b0;
    c = 0;
    while (done !== 1'b1 && c < 40) begin
      @(posedge clk);
      #1;
      c++;
      if (c == 3) begin
        in_number = ~8'h0F; key = 2'b10; start = 1'b1; arif = 4'd5;
      end else if (c == 4) begin
        key = 2'b00; start = 1'b0;
      end
    end
    checks++;
    if (b !== 1'b1 || c !== 8) begin
      errors++; $display("FAIL mul_busy busy=%b cyc=%0d exp 1/8", b, c);
    end
    checks++;
    if (result !== 16'hFE01 || ind !== 16'hFE01) begin
      errors++;
      $display("FAIL mul_res got=%h ind=%h exp FE01", result, ind);
    end
    run_op(4'd5, c, b);
    checks++;
    if (result !== 16'h00FF) begin
      errors++; $display("FAIL mul_ignored_load got=%h exp 00FF", result);
    end
  endtask

  task automatic test_div;
    int c; logic b;
    load(2'b10, 8'd200);
    load(2'b01, 8'd7);
    run_op(4'd3, c, b);
    checks++;
    if (result !== 16'd28 || c !== 8 || err !== 1'b0) begin
      errors++;
      $display("FAIL div got=%0d cyc=%0d err=%b exp 28/8/0", result, c, err);
    end
    run_op(4'd4, c, b);
    checks++;
    if (result !== 16'd4 || c !== 8) begin
      errors++; $display("FAIL mod got=%0d cyc=%0d exp 4/8", result, c);
    end
    load(2'b01, 8'd0);
    run_op(4'd3, c, b);
    checks++;
    if (result !== 16'h00FF || err !== 1'b1 || c !== 1 || led !== 3'b000) begin
      errors++;
      $display("FAIL div0 got=%h err=%b cyc=%0d led=%b exp 00FF/1/1/000",
               result, err, c, led);
    end
    run_op(4'd4, c, b);
    checks++;
    if (result !== 16'd200 || err !== 1'b1) begin
      errors++; $display("FAIL mod0 got=%0d err=%b exp 200/1", result, err);
    end
  endtask

  task automatic test_illegal;
    int c; logic b;
    run_op(4'd9, c, b);
    checks++;
    if (result !== 16'h0 || err !== 1'b1 || ovf !== 1'b0 || c !== 1) begin
      errors++;
      $display("FAIL illegal got=%h err=%b ovf=%b cyc=%0d exp 0000/1/0/1",
               result, err, ovf, c);
    end
    run_op(4'd0, c, b);
    checks++;
    if (result !== 16'd200 || err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear got=%0d err=%b exp 200/0", result, err);
    end
  endtask

  task automatic test_reset_mid;
    load(2'b01, 8'd3);
    @(negedge clk);
    arif = 4'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, err, ovf} !== 4'b0000 || led !== 3'b110) begin
      errors++;
      $display("FAIL rst_mid flags=%b led=%b exp 0000/110",
               {busy, done, err, ovf}, led);
    end
    checks++;
    if (result !== 16'h0 || ind !== 16'h0) begin
      errors++;
      $display("FAIL rst_mid_val result=%h ind=%h exp 0000", result, ind);
    end
    key = 2'b10;
    in_number = ~8'h33;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (led !== 3'b110 || ind !== 16'h0) begin
      errors++;
      $display("FAIL held_key led=%b ind=%h exp 110/0000", led, ind);
    end
    key = 2'b00;
  endtask

  task automatic test_start_key;
    int c;
    load(2'b01, 8'd3);
    @(negedge clk);
    in_number = ~8'd50;
    key = 2'b10;
    start = 1'b1;
    arif = 4'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    key = 2'b00;
    c = 0;
    while (done !== 1'b1 && c < 40) begin
      @(posedge clk);
      #1;
      c++;
    end
    checks++;
    if (result !== 16'd3 || c !== 1) begin
      errors++;
      $display("FAIL start_key got=%0d cyc=%0d exp 3/1", result, c);
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub_logic;
    test_mul_busy;
    test_div;
    test_illegal;
    test_reset_mid;
    test_start_key;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
